// File: rtl/cpu_defs.sv
// Shared widths, bus layouts and state encodings for the memory pipeline stage.
package cpu_defs;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned REG_AW       = 5;
    localparam int unsigned EX_MEM_BUS_W = 145;
    localparam int unsigned EXCEPT_BUS_W = 87;
    localparam int unsigned MEM_WB_BUS_W = 103;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } mem_state_e;

    // Execute -> memory payload, first member is the MSB.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   ir;
        logic              ld_b;
        logic              ld_bu;
        logic              ld_h;
        logic              ld_hu;
        logic              ld_w;
        logic              st_b;
        logic              st_h;
        logic              st_w;
        logic              mem_we;
        logic              res_from_mem;
        logic              gr_we;
        logic [XLEN-1:0]   rkd;
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   result;
    } ex_mem_t;

    // Memory -> writeback payload.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   ir;
        logic              gr_we;
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   final_result;
    } mem_wb_t;

    // An instruction touches memory only if it is a load/store with no upstream exception.
    function automatic logic needs_mem(input ex_mem_t b, input logic [EXCEPT_BUS_W-1:0] exc);
        return (b.mem_we | b.res_from_mem) & ~(|exc);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane/strobe generation and load lane extraction with sign/zero extension.
module mem_align
    import cpu_defs::*;
(
    input  logic [1:0]      i_addr_lo,
    input  logic            i_ld_b,
    input  logic            i_ld_bu,
    input  logic            i_ld_h,
    input  logic            i_ld_hu,
    input  logic            i_ld_w,
    input  logic            i_st_b,
    input  logic            i_st_h,
    input  logic            i_st_w,
    input  logic [XLEN-1:0] i_rkd,
    input  logic [XLEN-1:0] i_rdata,
    output logic [1:0]      o_size,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_load_data
);

    logic       w_is_byte;
    logic       w_is_half;
    logic [7:0] w_byte_lane;
    logic [15:0] w_half_lane;

    assign w_is_byte = i_ld_b | i_ld_bu | i_st_b;
    assign w_is_half = i_ld_h | i_ld_hu | i_st_h;
    assign o_size    = w_is_byte ? SIZE_BYTE : (w_is_half ? SIZE_HALF : SIZE_WORD);

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_rkd;
        if (i_st_b) begin
            o_wstrb = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_rkd[7:0]}};
        end else if (i_st_h) begin
            o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_rkd[15:0]}};
        end else if (i_st_w) begin
            o_wstrb = 4'b1111;
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte_lane = i_rdata[7:0];
            2'd1:    w_byte_lane = i_rdata[15:8];
            2'd2:    w_byte_lane = i_rdata[23:16];
            default: w_byte_lane = i_rdata[31:24];
        endcase
        w_half_lane = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        if (i_ld_b)       o_load_data = {{24{w_byte_lane[7]}}, w_byte_lane};
        else if (i_ld_bu) o_load_data = {24'b0, w_byte_lane};
        else if (i_ld_h)  o_load_data = {{16{w_half_lane[15]}}, w_half_lane};
        else if (i_ld_hu) o_load_data = {16'b0, w_half_lane};
        else if (i_ld_w)  o_load_data = i_rdata;
        else              o_load_data = '0;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-SRAM request per load/store and hands results to writeback.
module mem_stage
    import cpu_defs::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [EX_MEM_BUS_W-1:0] ex_to_mem_bus,
    input  logic [EXCEPT_BUS_W-1:0] ex_except_bus,
    input  logic                    ex_to_mem,
    output logic                    mem_allowin,
    input  logic                    wb_allowin,
    input  logic                    flush,
    output logic                    data_sram_req,
    output logic                    data_sram_wr,
    output logic [1:0]              data_sram_size,
    output logic [3:0]              data_sram_wstrb,
    output logic [XLEN-1:0]         data_sram_addr,
    output logic [XLEN-1:0]         data_sram_wdata,
    input  logic                    data_sram_addr_ok,
    input  logic                    data_sram_data_ok,
    input  logic [XLEN-1:0]         data_sram_rdata,
    output logic                    fwd_valid,
    output logic [REG_AW-1:0]       fwd_addr,
    output logic [XLEN-1:0]         fwd_data,
    output logic                    fwd_stall,
    output logic [MEM_WB_BUS_W-1:0] mem_to_wb_bus,
    output logic [EXCEPT_BUS_W-1:0] mem_except_bus,
    output logic                    mem_to_wb
);

    ex_mem_t                 w_ex_in;
    ex_mem_t                 r_buf;
    logic [EXCEPT_BUS_W-1:0] r_exc;
    logic [XLEN-1:0]         r_rdata;
    mem_state_e              r_state;
    mem_state_e              w_state_nxt;
    mem_state_e              w_issue_state;
    logic                    w_valid;
    logic                    w_readygo;
    logic                    w_latch;
    logic                    w_mem_to_wb;
    logic [XLEN-1:0]         w_load_data;
    logic [XLEN-1:0]         w_final_result;
    mem_wb_t                 w_wb_next;

    assign w_ex_in       = ex_mem_t'(ex_to_mem_bus);
    assign w_valid       = r_buf.valid & ~flush;
    assign w_readygo     = (r_state == ST_DONE);
    assign w_mem_to_wb   = w_readygo & wb_allowin;
    // A flush also kills whatever upstream offers in the same cycle.
    assign w_latch       = ex_to_mem & ~flush;
    assign w_issue_state = needs_mem(w_ex_in, ex_except_bus) ? ST_REQ : ST_DONE;

    assign mem_allowin = (~w_valid | w_mem_to_wb) & (r_state != ST_CANCEL);
    assign mem_to_wb   = w_mem_to_wb;

    // Instruction and exception buffers; valid drops once the instruction leaves or is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
            r_exc <= '0;
        end else if (w_latch) begin
            r_buf <= w_ex_in;
            r_exc <= ex_except_bus;
        end else if (flush | w_mem_to_wb) begin
            r_buf.valid <= 1'b0;
        end
    end

    // Load data capture on the response of a live request.
    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= '0;
        else if ((r_state == ST_WAIT) & data_sram_data_ok)
            r_rdata <= data_sram_rdata;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: request, wait for response, hand off; a flushed in-flight request drains in CANCEL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_latch) w_state_nxt = w_issue_state;
            ST_REQ: begin
                if (flush)                  w_state_nxt = data_sram_addr_ok ? ST_CANCEL : ST_IDLE;
                else if (data_sram_addr_ok) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush)                  w_state_nxt = data_sram_data_ok ? ST_IDLE : ST_CANCEL;
                else if (data_sram_data_ok) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (flush)            w_state_nxt = ST_IDLE;
                else if (w_mem_to_wb) w_state_nxt = w_latch ? w_issue_state : ST_IDLE;
            end
            ST_CANCEL: if (data_sram_data_ok) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    mem_align u_align (
        .i_addr_lo   (r_buf.result[1:0]),
        .i_ld_b      (r_buf.ld_b),
        .i_ld_bu     (r_buf.ld_bu),
        .i_ld_h      (r_buf.ld_h),
        .i_ld_hu     (r_buf.ld_hu),
        .i_ld_w      (r_buf.ld_w),
        .i_st_b      (r_buf.st_b),
        .i_st_h      (r_buf.st_h),
        .i_st_w      (r_buf.st_w),
        .i_rkd       (r_buf.rkd),
        .i_rdata     (r_rdata),
        .o_size      (data_sram_size),
        .o_wstrb     (data_sram_wstrb),
        .o_wdata     (data_sram_wdata),
        .o_load_data (w_load_data)
    );

    assign data_sram_req  = (r_state == ST_REQ);
    assign data_sram_wr   = r_buf.mem_we;
    assign data_sram_addr = r_buf.result;

    assign w_final_result = r_buf.res_from_mem ? w_load_data : r_buf.result;

    assign fwd_valid = w_valid & r_buf.gr_we;
    assign fwd_addr  = r_buf.waddr;
    assign fwd_data  = w_final_result;
    assign fwd_stall = w_valid & r_buf.res_from_mem & (r_state != ST_DONE);

    // Writeback payload; register write is suppressed for excepting instructions.
    always_comb begin
        w_wb_next              = '0;
        w_wb_next.valid        = w_valid;
        w_wb_next.pc           = r_buf.pc;
        w_wb_next.ir           = r_buf.ir;
        w_wb_next.gr_we        = r_buf.gr_we & ~(|r_exc);
        w_wb_next.waddr        = r_buf.waddr;
        w_wb_next.final_result = w_final_result;
    end

    // Output registers toward writeback: load on handoff, clear when writeback idles, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_to_wb_bus  <= '0;
            mem_except_bus <= '0;
        end else if (w_mem_to_wb) begin
            mem_to_wb_bus  <= w_wb_next;
            mem_except_bus <= r_exc;
        end else if (wb_allowin & ~w_readygo) begin
            mem_to_wb_bus  <= '0;
            mem_except_bus <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized instruction stream.
module tb_mem_stage;

    localparam int unsigned CW      = 145;
    localparam int          MAX_CYC = 2000;

    typedef enum int {K_ALU, K_LDB, K_LDBU, K_LDH, K_LDHU, K_LDW, K_STB, K_STH, K_STW} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] rkd;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [4:0]  waddr;
        logic        gr_we;
        logic [86:0] exc;
        int          aw;
        int          dw;
    } inst_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [144:0] ex_to_mem_bus;
    logic [86:0]  ex_except_bus;
    logic         ex_to_mem;
    logic         mem_allowin;
    logic         wb_allowin;
    logic         flush;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         fwd_valid;
    logic [4:0]   fwd_addr;
    logic [31:0]  fwd_data;
    logic         fwd_stall;
    logic [102:0] mem_to_wb_bus;
    logic [86:0]  mem_except_bus;
    logic         mem_to_wb;

    int          n_checks = 0;
    int          n_fail   = 0;
    inst_t       stim[$];
    int          req_cyc, stall_cyc, stream_cyc;
    logic [102:0] last_wb;
    logic [3:0]  last_wstrb;
    logic [31:0] last_wdata;
    logic [1:0]  last_size;
    logic        last_wr;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .ex_except_bus     (ex_except_bus),
        .ex_to_mem         (ex_to_mem),
        .mem_allowin       (mem_allowin),
        .wb_allowin        (wb_allowin),
        .flush             (flush),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .fwd_valid         (fwd_valid),
        .fwd_addr          (fwd_addr),
        .fwd_data          (fwd_data),
        .fwd_stall         (fwd_stall),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .mem_except_bus    (mem_except_bus),
        .mem_to_wb         (mem_to_wb)
    );

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_load(input kind_e k);
        return k inside {K_LDB, K_LDBU, K_LDH, K_LDHU, K_LDW};
    endfunction

    function automatic bit is_store(input kind_e k);
        return k inside {K_STB, K_STH, K_STW};
    endfunction

    function automatic logic [144:0] pack(input inst_t t);
        return {1'b1, t.pc, t.ir,
                t.kind == K_LDB, t.kind == K_LDBU, t.kind == K_LDH, t.kind == K_LDHU, t.kind == K_LDW,
                t.kind == K_STB, t.kind == K_STH, t.kind == K_STW,
                is_store(t.kind), is_load(t.kind), t.gr_we, t.rkd, t.waddr, t.addr};
    endfunction

    // Reference rules: access size, byte enables, lane data and load result from the address.
    function automatic logic [1:0] exp_size(input kind_e k);
        if (k inside {K_LDB, K_LDBU, K_STB}) return 2'd0;
        if (k inside {K_LDH, K_LDHU, K_STH}) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [3:0] exp_wstrb(input inst_t t);
        int off = int'(t.addr[1:0]);
        case (t.kind)
            K_STB:   return 4'(1 << off);
            K_STH:   return 4'(3 << (off & 2));
            K_STW:   return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input inst_t t);
        case (t.kind)
            K_STB:   return 32'(t.rkd[7:0]) * 32'h0101_0101;
            K_STH:   return 32'(t.rkd[15:0]) * 32'h0001_0001;
            default: return t.rkd;
        endcase
    endfunction

    function automatic logic [31:0] exp_final(input inst_t t);
        logic [31:0] b;
        logic [31:0] h;
        b = t.rdata >> (8 * int'(t.addr[1:0]));
        h = t.rdata >> (16 * int'(t.addr[1]));
        case (t.kind)
            K_LDB:   return 32'($signed(b[7:0]));
            K_LDBU:  return 32'(b[7:0]);
            K_LDH:   return 32'($signed(h[15:0]));
            K_LDHU:  return 32'(h[15:0]);
            K_LDW:   return t.rdata;
            default: return t.addr;
        endcase
    endfunction

    function automatic inst_t mk(input kind_e k, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] rd, input int aw, input int dw);
        inst_t t;
        t.kind  = k;
        t.pc    = 32'h1c00_0000 + 32'($urandom_range(4095) * 4);
        t.ir    = $urandom;
        t.rkd   = d;
        t.addr  = a;
        t.rdata = rd;
        t.waddr = 5'($urandom_range(31, 1));
        t.gr_we = !is_store(k);
        t.exc   = '0;
        t.aw    = aw;
        t.dw    = dw;
        return t;
    endfunction

    function automatic inst_t rand_inst();
        inst_t t;
        logic [31:0] a;
        kind_e k;
        k = kind_e'($urandom_range(8));
        a = $urandom;
        if (k inside {K_LDH, K_LDHU, K_STH}) a[0] = 1'b0;
        if (k inside {K_LDW, K_STW}) a[1:0] = 2'b00;
        t = mk(k, a, $urandom, $urandom, $urandom_range(3), $urandom_range(3));
        if (!is_load(k) && $urandom_range(9) == 0) t.exc = 87'(1) << $urandom_range(86);
        return t;
    endfunction

    task automatic check_wb(input inst_t t);
        logic [102:0] exp;
        exp = {1'b1, t.pc, t.ir, t.gr_we & (t.exc == '0), t.waddr, exp_final(t)};
        chk("wb_bus", CW'(mem_to_wb_bus), CW'(exp));
        chk("except_bus", CW'(mem_except_bus), CW'(t.exc));
        last_wb = mem_to_wb_bus;
    endtask

    // Drives stim[] through the stage with a responding memory, checking every request and handoff.
    task automatic run_stream(input int stall_pct);
        inst_t memq[$];
        inst_t wbq[$];
        inst_t cur;
        inst_t wexp;
        int    issued, retired, reqcnt, wcnt, cyc;
        bit    outstanding, pend;
        issued = 0; retired = 0; reqcnt = 0; wcnt = 0; cyc = 0;
        outstanding = 0; pend = 0; req_cyc = 0; stall_cyc = 0;
        cur = mk(K_LDW, 32'h0, 32'h0, 32'h0, 0, 0);
        while (retired < stim.size() && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                check_wb(wexp);
                pend = 0;
            end
            ex_to_mem = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
            wb_allowin = ($urandom_range(99) >= stall_pct);
            if (data_sram_req) req_cyc++;
            if (fwd_stall) stall_cyc++;
            if (outstanding) begin
                chk("single_outstanding", CW'(data_sram_req), CW'(1'b0));
                if (wcnt == cur.dw) begin
                    data_sram_data_ok = 1'b1;
                    data_sram_rdata   = cur.rdata;
                    outstanding       = 0;
                end else begin
                    wcnt++;
                end
            end else if (data_sram_req) begin
                if (reqcnt == 0) begin
                    if (memq.size() == 0) begin
                        chk("unexpected_req", CW'(data_sram_req), CW'(1'b0));
                        cur = mk(K_LDW, data_sram_addr, 32'h0, 32'h0, 0, 0);
                    end else begin
                        cur = memq.pop_front();
                    end
                    last_wstrb = data_sram_wstrb; last_wdata = data_sram_wdata;
                    last_size  = data_sram_size;  last_wr    = data_sram_wr;
                end
                chk("req_addr", CW'(data_sram_addr), CW'(cur.addr));
                chk("req_wr", CW'(data_sram_wr), CW'(is_store(cur.kind)));
                chk("req_size", CW'(data_sram_size), CW'(exp_size(cur.kind)));
                chk("req_wstrb", CW'(data_sram_wstrb), CW'(exp_wstrb(cur)));
                if (is_store(cur.kind)) chk("req_wdata", CW'(data_sram_wdata), CW'(exp_wdata(cur)));
                if (reqcnt == cur.aw) begin
                    data_sram_addr_ok = 1'b1;
                    outstanding = 1; wcnt = 0; reqcnt = 0;
                end else begin
                    reqcnt++;
                end
            end
            #1;
            if (issued < stim.size() && mem_allowin) begin
                ex_to_mem     = 1'b1;
                ex_to_mem_bus = pack(stim[issued]);
                ex_except_bus = stim[issued].exc;
                if ((is_load(stim[issued].kind) || is_store(stim[issued].kind)) && stim[issued].exc == '0)
                    memq.push_back(stim[issued]);
                wbq.push_back(stim[issued]);
                issued++;
            end
            #1;
            if (mem_to_wb) begin
                chk("retire_expected", CW'(wbq.size() > 0), CW'(1'b1));
                if (wbq.size() > 0) begin
                    wexp = wbq.pop_front();
                    chk("fwd_valid", CW'(fwd_valid), CW'(wexp.gr_we));
                    chk("fwd_addr", CW'(fwd_addr), CW'(wexp.waddr));
                    chk("fwd_data", CW'(fwd_data), CW'(exp_final(wexp)));
                    chk("fwd_stall_done", CW'(fwd_stall), CW'(1'b0));
                    pend = 1;
                end
                retired++;
            end
        end
        if (pend) begin
            @(negedge clk);
            check_wb(wexp);
        end
        chk("stream_complete", CW'(retired), CW'(stim.size()));
        ex_to_mem = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; wb_allowin = 1'b1;
        stream_cyc = cyc;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        inst_t a;
        // Reset dominates every input.
        rst = 1'b1; flush = 1'b1; wb_allowin = 1'b1;
        ex_to_mem = 1'b1; ex_to_mem_bus = pack(mk(K_LDW, 32'h100, 32'h0, 32'h0, 0, 0));
        ex_except_bus = '0; data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wb_bus", CW'(mem_to_wb_bus), CW'(103'b0));
        chk("rst_except_bus", CW'(mem_except_bus), CW'(87'b0));
        chk("rst_req", CW'(data_sram_req), CW'(1'b0));
        chk("rst_fwd_valid", CW'(fwd_valid), CW'(1'b0));
        chk("rst_fwd_stall", CW'(fwd_stall), CW'(1'b0));
        ex_to_mem = 1'b0; flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_allowin", CW'(mem_allowin), CW'(1'b1));
        chk("post_rst_req", CW'(data_sram_req), CW'(1'b0));
        chk("post_rst_handoff", CW'(mem_to_wb), CW'(1'b0));

        // Signed and unsigned byte loads from the top lane.
        stim = {};
        stim.push_back(mk(K_LDB, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0));
        run_stream(0);
        chk("ld_b_result", CW'(last_wb[31:0]), CW'(32'hFFFF_FF80));
        stim = {};
        stim.push_back(mk(K_LDBU, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0));
        run_stream(0);
        chk("ld_bu_result", CW'(last_wb[31:0]), CW'(32'h0000_0080));

        // Upper-half store.
        stim = {};
        stim.push_back(mk(K_STH, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 1, 0));
        run_stream(0);
        chk("st_h_wstrb", CW'(last_wstrb), CW'(4'b1100));
        chk("st_h_wdata", CW'(last_wdata), CW'(32'hABCD_ABCD));
        chk("st_h_size", CW'(last_size), CW'(2'd1));
        chk("st_h_wr", CW'(last_wr), CW'(1'b1));

        // Slow memory: three cycles before accept, two extra before response.
        stim = {};
        stim.push_back(mk(K_LDW, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 3, 2));
        run_stream(0);
        chk("slow_req_cycles", CW'(req_cyc), CW'(4));
        chk("slow_stall_cycles", CW'(stall_cyc), CW'(7));
        chk("slow_latency", CW'(stream_cyc), CW'(9));

        // Flush while waiting for the response; the late response must be dropped.
        a = mk(K_LDW, 32'h0000_4000, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        ex_to_mem = 1'b1; ex_to_mem_bus = pack(a); ex_except_bus = '0;
        @(negedge clk);
        ex_to_mem = 1'b0;
        #1;
        chk("flush_req", CW'(data_sram_req), CW'(1'b1));
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("cancel_allowin", CW'(mem_allowin), CW'(1'b0));
        chk("cancel_req", CW'(data_sram_req), CW'(1'b0));
        chk("cancel_fwd_valid", CW'(fwd_valid), CW'(1'b0));
        @(negedge clk);
        #1;
        chk("cancel_allowin_hold", CW'(mem_allowin), CW'(1'b0));
        chk("cancel_handoff", CW'(mem_to_wb), CW'(1'b0));
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("post_cancel_allowin", CW'(mem_allowin), CW'(1'b1));
        chk("post_cancel_handoff", CW'(mem_to_wb), CW'(1'b0));
        chk("post_cancel_bus", CW'(mem_to_wb_bus), CW'(103'b0));
        stim = {};
        stim.push_back(mk(K_LDW, 32'h0000_4004, 32'h0, 32'h1357_9BDF, 1, 1));
        run_stream(0);
        chk("after_cancel_result", CW'(last_wb[31:0]), CW'(32'h1357_9BDF));

        // Misaligned store with ALE raised upstream, then an excepting ALU op.
        stim = {};
        a = mk(K_STW, 32'h0000_1001, 32'h5555_AAAA, 32'h0, 0, 0);
        a.exc = 87'h1;
        stim.push_back(a);
        a = mk(K_ALU, 32'h0BAD_0001, 32'h0, 32'h0, 0, 0);
        a.exc = 87'h1;
        stim.push_back(a);
        run_stream(0);
        chk("ale_no_req", CW'(req_cyc), CW'(0));
        chk("ale_gr_we", CW'(last_wb[37]), CW'(1'b0));
        chk("ale_except_out", CW'(mem_except_bus), CW'(87'h0));

        // ALU, zero-wait load, ALU: no bubbles around the load.
        stim = {};
        stim.push_back(mk(K_ALU, 32'h0000_0111, 32'h0, 32'h0, 0, 0));
        stim.push_back(mk(K_LDW, 32'h0000_5000, 32'h0, 32'h2468_ACE0, 0, 0));
        stim.push_back(mk(K_ALU, 32'h0000_0222, 32'h0, 32'h0, 0, 0));
        run_stream(0);
        chk("b2b_cycles", CW'(stream_cyc), CW'(6));

        // Random mix with memory latency and writeback backpressure.
        stim = {};
        for (int i = 0; i < 60; i++) stim.push_back(rand_inst());
        run_stream(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
